// File: rtl/sa_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sa_tile_scheduler
// Purpose  : Walks an M x N output layer as TILE_DIM x TILE_DIM tiles in
//            row-major order. For each tile it pulses the systolic array,
//            captures the packed accumulator tile on tile_done, then drains
//            the tile to the output RAM with a per-column bias added.
// Ports    : clk, rstn (async, active-low)
//            start, M, N           - layer request from the accelerator FSM
//            tile_start, tile_row, tile_col, tile_done, tile_result
//                                  - systolic array controller handshake
//            bias_en, bias_addr, bias_rdata        - bias RAM (1-cycle read)
//            out_en, out_we, out_addr, out_wdata   - output RAM write port
//            busy, done            - status
// Revision : 1.0 - initial release
// ============================================================================
module sa_tile_scheduler #(
    parameter int TILE_DIM   = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic                                     start,
    input  logic [31:0]                              M,
    input  logic [31:0]                              N,
    output logic                                     tile_start,
    output logic [31:0]                              tile_row,
    output logic [31:0]                              tile_col,
    input  logic                                     tile_done,
    input  logic [TILE_DIM*TILE_DIM*2*DATA_WIDTH-1:0] tile_result,
    output logic                                     bias_en,
    output logic [ADDR_WIDTH-1:0]                    bias_addr,
    input  logic [DATA_WIDTH-1:0]                    bias_rdata,
    output logic                                     out_en,
    output logic                                     out_we,
    output logic [ADDR_WIDTH-1:0]                    out_addr,
    output logic [2*DATA_WIDTH-1:0]                  out_wdata,
    output logic                                     busy,
    output logic                                     done
);

    localparam int                  c_nelem = TILE_DIM * TILE_DIM;
    localparam int                  c_acc_w = 2 * DATA_WIDTH;
    localparam int                  c_cnt_w = $clog2(c_nelem + 1);
    localparam logic [31:0]         c_td    = 32'(TILE_DIM);
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(c_nelem);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_FINI  = 3'd4
    } state_t;

    state_t                          r_state;
    logic [31:0]                     r_m;
    logic [31:0]                     r_n;
    logic [31:0]                     r_nt_r;
    logic [31:0]                     r_nt_c;
    logic [31:0]                     r_row;
    logic [31:0]                     r_col;
    logic [c_cnt_w-1:0]              r_d;
    logic [c_nelem*c_acc_w-1:0]      r_capture;

    // Tile counts computed in 33 bits so M/N near 2^32 cannot overflow.
    logic [32:0]                     w_nt_r_full;
    logic [32:0]                     w_nt_c_full;
    logic [c_cnt_w-1:0]              w_wr_idx;
    logic [31:0]                     w_rd_gr, w_rd_gc;
    logic [31:0]                     w_wr_gr, w_wr_gc;
    logic [31:0]                     w_lin;
    logic                            w_in_drain;
    logic                            w_rd_ok;
    logic                            w_wr_ok;
    logic [c_acc_w-1:0]              w_elem;
    logic [c_acc_w-1:0]              w_bias_ext;

    assign w_nt_r_full = ({1'b0, M} + 33'(TILE_DIM - 1)) / 33'(TILE_DIM);
    assign w_nt_c_full = ({1'b0, N} + 33'(TILE_DIM - 1)) / 33'(TILE_DIM);

    // Read side handles element d; write side trails by one cycle (d-1)
    // so the bias word requested for an element arrives as it is written.
    assign w_wr_idx   = r_d - c_cnt_w'(1);
    assign w_rd_gr    = r_row * c_td + 32'(r_d) / c_td;
    assign w_rd_gc    = r_col * c_td + 32'(r_d) % c_td;
    assign w_wr_gr    = r_row * c_td + 32'(w_wr_idx) / c_td;
    assign w_wr_gc    = r_col * c_td + 32'(w_wr_idx) % c_td;
    assign w_lin      = w_wr_gr * r_n + w_wr_gc;

    assign w_in_drain = (r_state == S_DRAIN);
    assign w_rd_ok    = w_in_drain && (r_d < c_last)
                        && (w_rd_gr < r_m) && (w_rd_gc < r_n);
    assign w_wr_ok    = w_in_drain && (r_d != '0)
                        && (w_wr_gr < r_m) && (w_wr_gc < r_n);

    always_comb begin
        w_elem = '0;
        for (int e = 0; e < c_nelem; e++) begin
            if (w_wr_idx == c_cnt_w'(e)) begin
                w_elem = r_capture[e*c_acc_w +: c_acc_w];
            end
        end
    end

    assign w_bias_ext = {{(c_acc_w - DATA_WIDTH){bias_rdata[DATA_WIDTH-1]}}, bias_rdata};

    // Strobes and data are decoded from registered state and gated, so an
    // asynchronous reset forces every output to zero without a clock edge.
    assign tile_start = (r_state == S_ISSUE);
    assign tile_row   = r_row;
    assign tile_col   = r_col;
    assign bias_en    = w_rd_ok;
    assign bias_addr  = w_rd_ok ? w_rd_gc[ADDR_WIDTH-1:0] : '0;
    assign out_en     = w_wr_ok;
    assign out_we     = w_wr_ok;
    assign out_addr   = w_wr_ok ? w_lin[ADDR_WIDTH-1:0] : '0;
    assign out_wdata  = w_wr_ok ? (w_elem + w_bias_ext) : '0;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FINI);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_m       <= '0;
            r_n       <= '0;
            r_nt_r    <= '0;
            r_nt_c    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_d       <= '0;
            r_capture <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m    <= M;
                        r_n    <= N;
                        r_nt_r <= w_nt_r_full[31:0];
                        r_nt_c <= w_nt_c_full[31:0];
                        r_row  <= '0;
                        r_col  <= '0;
                        r_d    <= '0;
                        r_state <= ((M == 32'd0) || (N == 32'd0)) ? S_FINI : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (tile_done) begin
                        r_capture <= tile_result;
                        r_d       <= '0;
                        r_state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_d == c_last) begin
                        r_d <= '0;
                        if (r_col < r_nt_c - 32'd1) begin
                            r_col   <= r_col + 32'd1;
                            r_state <= S_ISSUE;
                        end else if (r_row < r_nt_r - 32'd1) begin
                            r_col   <= '0;
                            r_row   <= r_row + 32'd1;
                            r_state <= S_ISSUE;
                        end else begin
                            r_state <= S_FINI;
                        end
                    end else begin
                        r_d <= r_d + c_cnt_w'(1);
                    end
                end
                S_FINI: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
